// File: rtl/avmm_usm_port_arbiter.sv
// avmm_usm_port_arbiter: round-robin share of one USM AVMM host channel with an in-order read tag FIFO.
// Optional USM_ARB_GRANT_CNT_EN adds grant_cnt, one 32-bit grant counter per port.
module avmm_usm_port_arbiter #(
  parameter int NUM_PORTS        = 2,
  parameter int ADDR_WIDTH       = 48,
  parameter int DATA_WIDTH       = 512,
  parameter int BURSTCOUNT_WIDTH = 5,
  parameter int TAG_DEPTH        = 64
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_PORTS-1:0]                   src_read,
  input  logic [NUM_PORTS-1:0]                   src_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]        src_address,
  input  logic [NUM_PORTS*BURSTCOUNT_WIDTH-1:0]  src_burstcount,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]        src_writedata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]      src_byteenable,
  output logic [NUM_PORTS-1:0]                   src_waitrequest,
  output logic [DATA_WIDTH-1:0]                  src_readdata,
  output logic [NUM_PORTS-1:0]                   src_readdatavalid,
  output logic                                   snk_read,
  output logic                                   snk_write,
  output logic [ADDR_WIDTH-1:0]                  snk_address,
  output logic [BURSTCOUNT_WIDTH-1:0]            snk_burstcount,
  output logic [DATA_WIDTH-1:0]                  snk_writedata,
  output logic [DATA_WIDTH/8-1:0]                snk_byteenable,
  input  logic                                   snk_waitrequest,
  input  logic [DATA_WIDTH-1:0]                  snk_readdata,
  input  logic                                   snk_readdatavalid,
  output logic                                   rsp_err
`ifdef USM_ARB_GRANT_CNT_EN
  ,
  output logic [NUM_PORTS*32-1:0]                grant_cnt
`endif
);
  localparam int PW  = $clog2(NUM_PORTS);
  localparam int TW  = $clog2(TAG_DEPTH);
  localparam int BW  = BURSTCOUNT_WIDTH;
  localparam int BEW = DATA_WIDTH / 8;
  localparam logic [1:0] ST_ARB = 2'd0;
  localparam logic [1:0] ST_RD  = 2'd1;
  localparam logic [1:0] ST_WR  = 2'd2;

  logic [1:0]           state;
  logic [PW-1:0]        grant_id, last_grant, pick;
  logic [PW:0]          idx;
  logic                 found;
  logic [NUM_PORTS-1:0] req;
  logic [BW-1:0]        g_bc_raw, g_bc, wr_bc, wr_remaining, wr_cur;
  logic                 wr_started, wr_acc, rd_acc;
  logic [PW+BW-1:0]     tag_mem [TAG_DEPTH];
  logic [TW-1:0]        wp, rp;
  logic [TW:0]          count;
  logic                 tag_full, tag_empty;
  logic [PW-1:0]        head_port;
  logic [BW-1:0]        head_bc, rd_remaining, rd_cur;
  logic                 rd_active, rd_beat, rd_last;

  assign req = src_read | src_write;

  // Scan downwards so the closest port after last_grant is assigned last and wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      idx = {1'b0, last_grant} + (PW+1)'(i);
      idx = (idx >= (PW+1)'(NUM_PORTS)) ? idx - (PW+1)'(NUM_PORTS) : idx;
      if (req[idx[PW-1:0]]) begin
        pick  = idx[PW-1:0];
        found = 1'b1;
      end
    end
  end

  assign g_bc_raw       = src_burstcount[grant_id*BW +: BW];
  assign g_bc           = (g_bc_raw == '0) ? BW'(1) : g_bc_raw;
  assign wr_cur         = wr_started ? wr_remaining : g_bc;
  assign wr_acc         = (state == ST_WR) && src_write[grant_id] && !snk_waitrequest;
  assign rd_acc         = (state == ST_RD) && !snk_waitrequest && !tag_full;
  assign snk_read       = (state == ST_RD) && !tag_full;
  assign snk_write      = (state == ST_WR) && src_write[grant_id];
  assign snk_address    = src_address[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
  assign snk_writedata  = src_writedata[grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign snk_byteenable = src_byteenable[grant_id*BEW +: BEW];
  assign snk_burstcount = (state == ST_WR && wr_started) ? wr_bc : g_bc;

  always_comb begin
    src_waitrequest = '1;
    if (state == ST_RD) src_waitrequest[grant_id] = snk_waitrequest | tag_full;
    else if (state == ST_WR) src_waitrequest[grant_id] = snk_waitrequest;
  end

  assign tag_full          = count == (TW+1)'(TAG_DEPTH);
  assign tag_empty         = count == '0;
  assign head_port         = tag_mem[rp][PW+BW-1:BW];
  assign head_bc           = tag_mem[rp][BW-1:0];
  assign rd_cur            = rd_active ? rd_remaining : head_bc;
  assign rd_beat           = snk_readdatavalid && !tag_empty;
  assign rd_last           = rd_beat && rd_cur == BW'(1);
  assign src_readdata      = snk_readdata;
  assign src_readdatavalid = rd_beat ? (NUM_PORTS'(1) << head_port) : '0;

  always_ff @(posedge clk) begin
    if (rd_acc) tag_mem[wp] <= {grant_id, g_bc};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_ARB;
      grant_id     <= '0;
      last_grant   <= '0;
      wr_started   <= 1'b0;
      wr_bc        <= '0;
      wr_remaining <= '0;
      wp           <= '0;
      rp           <= '0;
      count        <= '0;
      rd_active    <= 1'b0;
      rd_remaining <= '0;
      rsp_err      <= 1'b0;
    end else begin
      if (state == ST_ARB && found) begin
        grant_id   <= pick;
        last_grant <= pick;
        wr_started <= 1'b0;
        state      <= src_read[pick] ? ST_RD : ST_WR;
      end
      if (rd_acc) state <= ST_ARB;
      if (wr_acc) begin
        wr_started   <= 1'b1;
        wr_bc        <= wr_started ? wr_bc : g_bc;
        wr_remaining <= wr_cur - BW'(1);
        if (wr_cur == BW'(1)) state <= ST_ARB;
      end
      if (rd_acc) wp <= wp + TW'(1);
      if (rd_last) rp <= rp + TW'(1);
      count <= count + {{TW{1'b0}}, rd_acc} - {{TW{1'b0}}, rd_last};
      if (rd_beat) begin
        rd_active    <= !rd_last;
        rd_remaining <= rd_cur - BW'(1);
      end
      if (snk_readdatavalid && tag_empty) rsp_err <= 1'b1;
    end
  end

`ifdef USM_ARB_GRANT_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) grant_cnt <= '0;
    else if (state == ST_ARB && found) grant_cnt[pick*32 +: 32] <= grant_cnt[pick*32 +: 32] + 32'd1;
  end
`endif
endmodule

// File: tb/tb_avmm_usm_port_arbiter.sv
// tb_avmm_usm_port_arbiter: directed checks of arbitration, write hold, tag FIFO limits and reset behaviour.
module tb_avmm_usm_port_arbiter;
  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    src_read, src_write;
  logic [95:0]   src_address;
  logic [9:0]    src_burstcount;
  logic [1023:0] src_writedata;
  logic [127:0]  src_byteenable;
  logic [1:0]    src_waitrequest, src_readdatavalid;
  logic [511:0]  src_readdata, snk_writedata, snk_readdata;
  logic          snk_read, snk_write, snk_waitrequest, snk_readdatavalid, rsp_err;
  logic [47:0]   snk_address;
  logic [4:0]    snk_burstcount;
  logic [63:0]   snk_byteenable;
`ifdef USM_ARB_GRANT_CNT_EN
  logic [63:0]   grant_cnt;
`endif
  int checks = 0;
  int failures = 0;

  localparam logic [47:0] A0 = 48'h0000_1000_00a0;
  localparam logic [47:0] A1 = 48'h0000_2000_00b1;

  avmm_usm_port_arbiter dut (
    .clk(clk), .reset(reset),
    .src_read(src_read), .src_write(src_write), .src_address(src_address),
    .src_burstcount(src_burstcount), .src_writedata(src_writedata),
    .src_byteenable(src_byteenable), .src_waitrequest(src_waitrequest),
    .src_readdata(src_readdata), .src_readdatavalid(src_readdatavalid),
    .snk_read(snk_read), .snk_write(snk_write), .snk_address(snk_address),
    .snk_burstcount(snk_burstcount), .snk_writedata(snk_writedata),
    .snk_byteenable(snk_byteenable), .snk_waitrequest(snk_waitrequest),
    .snk_readdata(snk_readdata), .snk_readdatavalid(snk_readdatavalid),
    .rsp_err(rsp_err)
`ifdef USM_ARB_GRANT_CNT_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; src_read = '0; src_write = '0; src_burstcount = '0;
    src_address = {A1, A0}; src_writedata = '0; src_byteenable = '1;
    snk_waitrequest = 1'b0; snk_readdata = '0; snk_readdatavalid = 1'b0;
    step; step; #1;
    chk("rst_waitreq", src_waitrequest, 2'b11);
    chk("rst_snk_read", snk_read, 0);
    chk("rst_snk_write", snk_write, 0);
    chk("rst_rdv", src_readdatavalid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    reset = 1'b0;
    step;
    // Port1 single read first so last_grant becomes 1.
    src_read = 2'b10; src_burstcount[5 +: 5] = 5'd1; #1;
    chk("prime_bubble", src_waitrequest, 2'b11);
    step;
    chk("prime_snk_read", snk_read, 1);
    chk("prime_waitreq", src_waitrequest, 2'b01);
    chk("prime_addr", snk_address, A1);
    step;
    src_read = '0; snk_readdatavalid = 1'b1; snk_readdata = 512'h55; #1;
    chk("prime_rdv", src_readdatavalid, 2'b10);
    step;
    snk_readdatavalid = 1'b0;
    // Test 1: simultaneous reads bc=4, port0 wins.
    src_read = 2'b11; src_burstcount = {5'd4, 5'd4};
    step;
    chk("t1_p0_addr", snk_address, A0);
    chk("t1_p0_waitreq", src_waitrequest, 2'b10);
    chk("t1_p0_bc", snk_burstcount, 4);
    step;
    src_read[0] = 1'b0; #1;
    chk("t1_bubble_waitreq", src_waitrequest, 2'b11);
    chk("t1_bubble_read", snk_read, 0);
    step;
    chk("t1_p1_addr", snk_address, A1);
    chk("t1_p1_waitreq", src_waitrequest, 2'b01);
    step;
    src_read = '0;
    for (int i = 0; i < 8; i++) begin
      snk_readdatavalid = 1'b1; snk_readdata = 512'(i + 100); #1;
      chk("t1_rdv", src_readdatavalid, (i < 4) ? 2'b01 : 2'b10);
      chk("t1_rdata", src_readdata, 512'(i + 100));
      step;
    end
    snk_readdatavalid = 1'b0; #1;
    chk("t1_rdv_idle", src_readdatavalid, 0);
    chk("t1_rsp_err", rsp_err, 0);
    // Test 2: port1 write bc=8 with a gap, port0 read waits.
    src_write = 2'b10; src_burstcount[5 +: 5] = 5'd8;
    step;
    src_read = 2'b01; src_burstcount[0 +: 5] = 5'd2;
    for (int w = 1; w <= 8; w++) begin
      if (w == 4) begin
        src_write[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
          #1;
          chk("t2_gap_write", snk_write, 0);
          chk("t2_gap_waitreq", src_waitrequest, 2'b01);
          step;
        end
        src_write[1] = 1'b1;
      end
      if (w == 2) src_burstcount[5 +: 5] = 5'd3;
      src_writedata[512 +: 512] = 512'(w); #1;
      chk("t2_write", snk_write, 1);
      chk("t2_data", snk_writedata, 512'(w));
      chk("t2_bc", snk_burstcount, 8);
      chk("t2_waitreq", src_waitrequest, 2'b01);
      step;
    end
    src_write = '0; #1;
    chk("t2_end_waitreq", src_waitrequest, 2'b11);
    chk("t2_end_write", snk_write, 0);
    step;
    chk("t2_p0_read", snk_read, 1);
    chk("t2_p0_addr", snk_address, A0);
    chk("t2_p0_waitreq", src_waitrequest, 2'b10);
    chk("t2_p0_bc", snk_burstcount, 2);
    step;
    src_read = '0;
    for (int i = 0; i < 2; i++) begin
      snk_readdatavalid = 1'b1; #1;
      chk("t2_rdv", src_readdatavalid, 2'b01);
      step;
    end
    snk_readdatavalid = 1'b0;
    // Test 4: sink stall for 5 cycles mid-write on port0.
    src_write = 2'b01; src_burstcount[0 +: 5] = 5'd4;
    step;
    for (int w = 1; w <= 4; w++) begin
      src_writedata[0 +: 512] = 512'(w);
      if (w == 3) begin
        snk_waitrequest = 1'b1;
        for (int k = 0; k < 5; k++) begin
          #1;
          chk("t4_stall_write", snk_write, 1);
          chk("t4_stall_waitreq", src_waitrequest, 2'b11);
          chk("t4_stall_data", snk_writedata, 512'(3));
          step;
        end
        snk_waitrequest = 1'b0;
      end
      #1;
      chk("t4_write", snk_write, 1);
      chk("t4_data", snk_writedata, 512'(w));
      chk("t4_waitreq", src_waitrequest, 2'b10);
      step;
    end
    #1;
    chk("t4_end_write", snk_write, 0);
    chk("t4_end_waitreq", src_waitrequest, 2'b11);
    src_write = '0;
    // Test 3: 64 outstanding reads fill the tag FIFO.
    src_read = 2'b01; src_burstcount[0 +: 5] = 5'd1;
    for (int i = 0; i < 64; i++) begin
      step;
      step;
    end
    step;
    chk("t3_full_waitreq", src_waitrequest, 2'b11);
    chk("t3_full_read", snk_read, 0);
    step;
    chk("t3_full_waitreq2", src_waitrequest, 2'b11);
    chk("t3_full_read2", snk_read, 0);
    snk_readdatavalid = 1'b1; #1;
    chk("t3_release_rdv", src_readdatavalid, 2'b01);
    step;
    snk_readdatavalid = 1'b0; #1;
    chk("t3_release_read", snk_read, 1);
    chk("t3_release_waitreq", src_waitrequest, 2'b10);
    step;
    src_read = '0;
    // Test 5: reset mid-burst at word 4.
    src_write = 2'b10; src_burstcount[5 +: 5] = 5'd8;
    step;
    for (int w = 1; w <= 3; w++) begin
      src_writedata[512 +: 512] = 512'(w);
      step;
    end
    src_writedata[512 +: 512] = 512'(4);
    reset = 1'b1; #1;
    chk("t5_async_waitreq", src_waitrequest, 2'b11);
    chk("t5_async_write", snk_write, 0);
    step;
    reset = 1'b0; #1;
    chk("t5_post_waitreq", src_waitrequest, 2'b11);
    chk("t5_post_write", snk_write, 0);
    chk("t5_post_err", rsp_err, 0);
    src_write = '0;
    snk_readdatavalid = 1'b1; #1;
    chk("t5_stray_rdv", src_readdatavalid, 0);
    step;
    snk_readdatavalid = 1'b0; #1;
    chk("t5_rsp_err", rsp_err, 1);
    step;
    chk("t5_rsp_err_sticky", rsp_err, 1);
`ifdef USM_ARB_GRANT_CNT_EN
    // Test 6: 10 alternating grants after reset.
    src_read = 2'b11; src_burstcount = {5'd1, 5'd1};
    for (int i = 0; i < 10; i++) begin
      step;
      step;
    end
    src_read = '0; #1;
    chk("t6_grant_cnt", grant_cnt, {32'd5, 32'd5});
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
